// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter slice.
// Address/data defaults match the control unit's D_Addr port.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    CPU,
    HOST,
    HOST_LOCK
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_HOST
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Read-return tag pipeline: one valid+owner slot per cycle
// of memory read latency, flushed synchronously.
module rd_tag_pipe
  import dmem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic   Clk,
  input  logic   flush,
  input  logic   push,
  input  owner_t push_own,
  output logic   pop,
  output owner_t pop_own,
  output logic   busy
);

  logic [RD_LAT-1:0] vld;
  owner_t            own [RD_LAT];

  always_ff @(posedge Clk) begin
    if (flush) begin
      vld <= '0;
    end else begin
      vld[0] <= push;
      for (int i = 1; i < RD_LAT; i++)
        vld[i] <= vld[i-1];
    end
    own[0] <= push_own;
    for (int i = 1; i < RD_LAT; i++)
      own[i] <= own[i-1];
  end

  assign pop     = vld[RD_LAT-1];
  assign pop_own = own[RD_LAT-1];
  assign busy    = |vld;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin CPU/host arbiter for the single-port data memory,
// with a bounded host burst lock and tagged read return.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state_q, state_d;
  owner_t            last_q, last_d;
  logic [3:0]        burst_q, burst_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] crd_q, hrd_q;
  logic              cpu_win, host_win, lock_hold;
  logic              pop, pipe_busy;
  owner_t            pop_own;

  assign lock_hold = (state_q == HOST_LOCK) & host_req & host_lock
                   & (burst_q < 4'(MAX_BURST));

  always_comb begin
    cpu_win  = 1'b0;
    host_win = 1'b0;
    if (!Reset) begin
      if (cpu_req & host_req) begin
        host_win = lock_hold | (last_q == OWN_CPU);
        cpu_win  = ~host_win;
      end else begin
        cpu_win  = cpu_req;
        host_win = host_req;
      end
    end
  end

  always_comb begin
    state_d = IDLE;
    last_d  = last_q;
    burst_d = burst_q;
    if (cpu_win) begin
      state_d = CPU;
      last_d  = OWN_CPU;
    end else if (host_win) begin
      state_d = host_lock ? HOST_LOCK : HOST;
      last_d  = OWN_HOST;
    end
    // Only host grants that keep the CPU waiting inside a lock count.
    if (cpu_win || state_d != HOST_LOCK)
      burst_d = '0;
    else if (host_win && state_q == HOST_LOCK && cpu_req
             && burst_q < 4'(MAX_BURST))
      burst_d = burst_q + 4'd1;
  end

  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wr    = 1'b0;
    unique case (1'b1)
      cpu_win: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wr    = cpu_wr;
      end
      host_win: begin
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        mem_wr    = host_wr;
      end
      default: ;
    endcase
    if (Reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      last_q  <= OWN_HOST;
      burst_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      crd_q   <= '0;
      hrd_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      if (cpu_rvalid)
        crd_q <= mem_rdata;
      if (host_rvalid)
        hrd_q <= mem_rdata;
    end
  end

  rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tags (
    .Clk     (Clk),
    .flush   (Reset),
    .push    ((cpu_win & ~cpu_wr) | (host_win & ~host_wr)),
    .push_own(host_win ? OWN_HOST : OWN_CPU),
    .pop     (pop),
    .pop_own (pop_own),
    .busy    (pipe_busy)
  );

  assign cpu_gnt     = cpu_win;
  assign host_gnt    = host_win;
  assign cpu_stall   = cpu_req & ~cpu_win;
  assign cpu_rvalid  = ~Reset & pop & (pop_own == OWN_CPU);
  assign host_rvalid = ~Reset & pop & (pop_own == OWN_HOST);
  assign cpu_rdata   = Reset ? '0 : (cpu_rvalid ? mem_rdata : crd_q);
  assign host_rdata  = Reset ? '0 : (host_rvalid ? mem_rdata : hrd_q);
  assign busy        = ~Reset & (pipe_busy | (state_q != IDLE));

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port 256x16 data memory. It sits between the control unit's data-memory port (D_Addr/D_Wr and the datapath write data) and a host/debug loader port, and drives the memory pins. It issues at most one access per cycle, tracks read latency, and returns read data to the owner. Arbitration is round-robin with an optional bounded host burst lock.

## Interface
- ADDR_W, 8, data memory address width
- DATA_W, 16, data word width
- RD_LAT, 1, memory read latency in cycles; legal values are 1 and 2
- MAX_BURST, 4, maximum consecutive locked host grants while the CPU is waiting; legal range 1..15

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held until granted
- cpu_wr  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_rdata  out  DATA_W  CPU read data
- host_req, host_wr, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host request, same semantics as the CPU port
- host_lock  in  1  keep the grant on host for back-to-back accesses
- host_gnt  out  1  host access issued this cycle
- host_rvalid  out  1  host_rdata valid
- host_rdata  out  DATA_W  host read data
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wr  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data, RD_LAT cycles after the address
- busy  out  1  read in flight or state != IDLE

## Operation
- States:
  - IDLE: no grant last cycle.
  - CPU: CPU granted last cycle.
  - HOST: host granted, unlocked.
  - HOST_LOCK: host granted with host_lock.
- Decision each cycle, combinational from requests and registered state:
  - Only one requester: that requester wins.
  - Both request: the requester that did not win last (last_win register) wins. The exception is HOST_LOCK with host_req & host_lock and burst_cnt < MAX_BURST, where host wins.
- burst_cnt counts consecutive host grants made while cpu_req = 1 in HOST_LOCK.
  - It clears on any CPU grant and on leaving HOST_LOCK.
  - At MAX_BURST with cpu_req = 1, the CPU wins the next cycle (forced yield), then the lock may resume.
- Memory drive:
  - The winner's addr, wdata and wr are muxed onto the mem_* outputs in the same cycle.
  - With no winner: mem_wr = 0, mem_addr and mem_wdata hold their last values.
- Read return: a granted read pushes an owner tag into an RD_LAT-deep shift register.
  - At the tail, the tagged owner's rvalid pulses for 1 cycle, with rdata = mem_rdata.
  - rdata of the non-owner holds its previous value.
- Writes produce no rvalid.
- last_win updates on every grant. Idle cycles leave it unchanged.

## Timing
- Grant is same-cycle (combinational): a request in cycle N, if it wins, has gnt = 1 in N and the memory access in N.
- Read data: rvalid in cycle N+RD_LAT.
- Back-to-back grants are allowed every cycle, and reads pipeline fully.
- A requester must hold its request fields stable until gnt. Changing fields before gnt is legal but undefined as to which value is used.
- Reset asserted in any cycle:
  - gnt outputs forced 0 in that cycle. mem_wr = 0. In-flight read tags flushed, so no rvalid after reset.
  - State = IDLE, last_win = HOST (so the CPU wins the first tie), burst_cnt = 0.
  - mem_addr = 0, mem_wdata = 0, rdata outputs = 0, busy = 0.
- A simultaneous read and write by different owners in consecutive cycles needs no special case; the memory is sequential per cycle.
- host_lock deasserted mid-burst: fall to HOST or CPU per the normal round-robin next cycle.

## Structure
- The shared package `dmem_pkg` holds:
  - the state enum (IDLE, CPU, HOST, HOST_LOCK)
  - the owner enum (OWN_CPU, OWN_HOST)
  - the ADDR_W/DATA_W defaults, matching the control unit's D_Addr width
- One sub-module, `rd_tag_pipe`: an RD_LAT-deep valid+owner shift register with synchronous flush.
- The top level holds the FSM, last_win, burst_cnt and the muxes.

## Test plan
- After reset, cpu_req=1 read 0xBC and host_req=1 read 0x10 in the same cycle:
  - cycle 0: cpu_gnt=1, mem_addr=0xBC.
  - cycle 1: host_gnt=1, mem_addr=0x10.
  - cpu_rvalid at cycle 1 and host_rvalid at cycle 2 (RD_LAT=1), with data from the memory model.
- Only the CPU issues writes to 0x00..0x03 back-to-back: cpu_gnt=1 for 4 cycles, mem_wr=1 each cycle, cpu_stall=0, no rvalid.
- host_lock=1, host_req continuous, cpu_req=1, MAX_BURST=4:
  - grants are host, host, host, host, cpu, then host again.
  - cpu_stall is high for exactly 4 cycles.
- Host reads issued during a cycle with Reset=1 at RD_LAT=2: no rvalid in the following 2 cycles, all outputs at reset values, state IDLE.
- Alternating contention for 10 cycles: grants strictly alternate, starting with the CPU, and every read returns to the correct owner with the correct data.
- Idle gap: no requests for 3 cycles → mem_wr=0, busy=0 after the last rvalid, last_win unchanged.
